// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter: default widths, FSM state codes and ALU opcodes.
package alu_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 2;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned OP_W_DEF    = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response bundle of the ALU share arbiter; slave = arbiter side,
// master = requesters plus the ALU instance.
interface alu_share_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        req_src;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*DATA_W-1:0] req_imm;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_imm;
  logic [OP_W-1:0]   alu_op;
  logic              alu_src;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;

  modport slave (
    input  req_valid, req_op, req_src, req_a, req_b, req_imm, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_imm, alu_op, alu_src, rsp_valid, rsp_id, rsp_data,
           rsp_zero
  );

  modport master (
    output req_valid, req_op, req_src, req_a, req_b, req_imm, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_imm, alu_op, alu_src, rsp_valid, rsp_id, rsp_data,
           rsp_zero
  );

endinterface

// File: rtl/alu_share_arbiter_rr_picker.sv
// Grant picker: round-robin starting after ptr, or lowest-index-wins when
// ALU_ARB_FIXED_PRIO_EN is defined (no ptr input then).
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
    gnt = (|req) ? (NUM_REQ'(1) << idx) : '0;
  end
`else
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  // Rotate so bit 0 is requester ptr+1, find first set, then rotate the offset back.
  always_comb begin
    rot = NUM_REQ'({req, req} >> (int'(ptr) + 1));
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off} + (ID_W + 1)'(1);
    if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
    idx = sum[ID_W-1:0];
    gnt = (|req) ? (NUM_REQ'(1) << idx) : '0;
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: accept, execute, respond.
// Build option ALU_ARB_FIXED_PRIO_EN swaps round-robin for fixed lowest-index priority.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               accept;

  logic [OP_W-1:0]    op_sel;
  logic               src_sel;
  logic [DATA_W-1:0]  a_sel, b_sel, imm_sel;

  logic [DATA_W-1:0]  alu_a_q, alu_b_q, alu_imm_q, rsp_data_q;
  logic [OP_W-1:0]    alu_op_q;
  logic               alu_src_q, rsp_zero_q;
  logic [ID_W-1:0]    rsp_id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req (bus.req_valid),
    .gnt (gnt),
    .idx (gnt_idx)
  );
`else
  logic [ID_W-1:0] ptr_q;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Reset to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else if (state_q == StResp && bus.rsp_ready) begin
      ptr_q <= rsp_id_q;
    end
  end
`endif

  assign accept = (state_q == StIdle) && (|bus.req_valid);

  always_comb begin
    op_sel  = '0;
    src_sel = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    imm_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_sel  = bus.req_op[i*OP_W +: OP_W];
        src_sel = bus.req_src[i];
        a_sel   = bus.req_a[i*DATA_W +: DATA_W];
        b_sel   = bus.req_b[i*DATA_W +: DATA_W];
        imm_sel = bus.req_imm[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_imm_q  <= '0;
      alu_op_q   <= '0;
      alu_src_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q   <= a_sel;
        alu_b_q   <= b_sel;
        alu_imm_q <= imm_sel;
        alu_op_q  <= op_sel;
        alu_src_q <= src_sel;
        rsp_id_q  <= gnt_idx;
      end
      if (state_q == StExec) begin
        rsp_data_q <= bus.alu_result;
        rsp_zero_q <= bus.alu_zero;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle) ? gnt : '0;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_imm   = alu_imm_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_src   = alu_src_q;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the alu_* port.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: unsupported opcodes give result 0 and zero flag 0.
  logic [31:0] alu_b_eff, alu_res;
  logic        alu_known;
  always_comb begin
    alu_b_eff = bus.alu_src ? bus.alu_imm : bus.alu_b;
    alu_res   = '0;
    alu_known = 1'b1;
    case (bus.alu_op)
      ALU_AND: alu_res = bus.alu_a & alu_b_eff;
      ALU_OR:  alu_res = bus.alu_a | alu_b_eff;
      ALU_ADD: alu_res = bus.alu_a + alu_b_eff;
      ALU_SUB: alu_res = bus.alu_a - alu_b_eff;
      default: alu_known = 1'b0;
    endcase
    bus.alu_result = alu_res;
    bus.alu_zero   = alu_known && (alu_res == 32'd0);
  end

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_src   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_imm   = '0;
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    bus.req_op[r*4 +: 4]    = op;
    bus.req_src[r]          = src;
    bus.req_a[r*32 +: 32]   = a;
    bus.req_b[r*32 +: 32]   = b;
    bus.req_imm[r*32 +: 32] = imm;
    bus.req_valid[r]        = 1'b1;
  endtask

  // Called just after a negedge; returns at the negedge(+1) where req_ready is seen, or -1.
  task automatic wait_accept(output int idx);
    idx = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (|bus.req_ready) begin
        for (int i = 0; i < 2; i++) if (bus.req_ready[i]) idx = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counts negedges after acceptance until rsp_valid; drops the masked requests first.
  task automatic wait_rsp(input logic [1:0] drop, output int cyc);
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = bus.req_valid & ~drop;
      #1;
      if (bus.rsp_valid) begin
        cyc = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 32'd0 || bus.rsp_id !== 1'b0 || bus.rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got data %h id %b zero %b want 0/0/0", bus.rsp_data, bus.rsp_id, bus.rsp_zero);
    end
    n_cmp++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_imm !== 32'd0 || bus.alu_op !== 4'd0 || bus.alu_src !== 1'b0) begin
      n_fail++; $display("FAIL reset_alu: got a %h b %h imm %h op %h src %b want all 0", bus.alu_a, bus.alu_b, bus.alu_imm, bus.alu_op, bus.alu_src);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL idle_no_req: got valid %b ready %b want 0 00", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    bus.rsp_ready = 1'b1;
    set_req(0, ALU_ADD, 1'b0, 32'd5, 32'd7, 32'd0);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL add_grant: got %b want 01", bus.req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_exec: got ready %b valid %b want 00 0", bus.req_ready, bus.rsp_valid);
    end
    n_cmp++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 || bus.alu_op !== ALU_ADD || bus.alu_src !== 1'b0) begin
      n_fail++; $display("FAIL add_alu_regs: got a %0d b %0d op %h src %b want 5 7 2 0", bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_src);
    end
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL add_rsp: got valid %b data %0d zero %b id %0d want 1 12 0 0", bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp_done: got %b want 0", bus.rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_sub_imm();
    int idx, cyc;
    bus.rsp_ready = 1'b1;
    set_req(1, ALU_SUB, 1'b1, 32'd9, 32'd3, 32'd9);
    wait_accept(idx);
    n_cmp++; if (idx !== 1) begin n_fail++; $display("FAIL sub_grant: got %0d want 1", idx); end
    wait_rsp(2'b10, cyc);
    n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL sub_latency: got %0d want 2", cyc); end
    n_cmp++; if (bus.rsp_data !== 32'd0 || bus.rsp_zero !== 1'b1 || bus.rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL sub_rsp: got data %0d zero %b id %0d want 0 1 1", bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    n_cmp++; if (bus.alu_src !== 1'b1 || bus.alu_imm !== 32'd9) begin
      n_fail++; $display("FAIL sub_alu_regs: got src %b imm %0d want 1 9", bus.alu_src, bus.alu_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_g[4];
    int idx, cyc;
    longint t_prev, t_now;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    t_prev = 0;
    bus.rsp_ready = 1'b1;
    set_req(0, ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
    set_req(1, ALU_OR, 1'b0, 32'd4, 32'd8, 32'd0);
    for (int k = 0; k < 4; k++) begin
      wait_accept(idx);
      t_now = $time;
      n_cmp++; if (idx !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, idx, exp_g[k]); end
      if (k > 0) begin
        n_cmp++; if (t_now - t_prev !== 30) begin n_fail++; $display("FAIL rr_period[%0d]: got %0d want 30", k, t_now - t_prev); end
      end
      t_prev = t_now;
      wait_rsp(2'b00, cyc);
      n_cmp++; if (bus.rsp_data !== ((exp_g[k] == 0) ? 32'd2 : 32'd12)) begin
        n_fail++; $display("FAIL rr_data[%0d]: got %0d want %0d", k, bus.rsp_data, (exp_g[k] == 0) ? 2 : 12);
      end
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int idx, cyc;
    bus.rsp_ready = 1'b0;
    set_req(0, ALU_ADD, 1'b0, 32'd3, 32'd4, 32'd0);
    set_req(1, ALU_OR, 1'b0, 32'd1, 32'd2, 32'd0);
    wait_accept(idx);
    n_cmp++; if (idx !== 0) begin n_fail++; $display("FAIL bp_grant: got %0d want 0", idx); end
    wait_rsp(2'b01, cyc);
    n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", cyc); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd7 || bus.rsp_id !== 1'b0 || bus.req_ready !== 2'b00 || bus.alu_a !== 32'd3) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid %b data %0d id %0d ready %b alu_a %0d want 1 7 0 00 3", k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, bus.alu_a);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: got valid %b ready %b want 0 10", bus.rsp_valid, bus.req_ready);
    end
    wait_rsp(2'b10, cyc);
    n_cmp++; if (cyc !== 2 || bus.rsp_data !== 32'd3 || bus.rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got cyc %0d data %0d id %0d want 2 3 1", cyc, bus.rsp_data, bus.rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_opcode();
    int idx, cyc;
    bus.rsp_ready = 1'b1;
    set_req(0, 4'b1010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    wait_accept(idx);
    n_cmp++; if (idx !== 0) begin n_fail++; $display("FAIL badop_grant: got %0d want 0", idx); end
    wait_rsp(2'b01, cyc);
    n_cmp++; if (bus.alu_op !== 4'b1010) begin n_fail++; $display("FAIL badop_pass: got %b want 1010", bus.alu_op); end
    n_cmp++; if (bus.rsp_data !== 32'd0 || bus.rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL badop_rsp: got data %h zero %b want 0 0", bus.rsp_data, bus.rsp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int idx, cyc;
    bus.rsp_ready = 1'b1;
    set_req(0, ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
    wait_accept(idx);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_now: got valid %b alu_a %0d want 0 0", bus.rsp_valid, bus.alu_a);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop: got %b want 0", bus.rsp_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    set_req(1, ALU_OR, 1'b0, 32'd5, 32'd0, 32'd0);
    set_req(0, ALU_AND, 1'b0, 32'd6, 32'd3, 32'd0);
    wait_accept(idx);
    n_cmp++; if (idx !== 0) begin n_fail++; $display("FAIL rst_mid_grant: got %0d want 0", idx); end
    wait_rsp(2'b01, cyc);
    n_cmp++; if (bus.rsp_data !== 32'd2 || bus.rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_rsp: got data %0d id %0d want 2 0", bus.rsp_data, bus.rsp_id);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_imm();
    test_round_robin();
    test_back_pressure();
    test_bad_opcode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (AND/OR/ADD/SUB, operand-2 mux, zero flag) between NUM_REQ requesters, e.g. the main datapath and a debug or address-generation agent.
- Accepts one request at a time over a valid/ready handshake and drives the ALU from registered operands.
- Captures alu_output/zero_flag and returns them, tagged with the requester id, over a valid/ready response channel.
- Sits between the requesters and the alu instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 4, ALU operation code width
ID_W, $clog2(NUM_REQ) (min 1), width of requester id

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_op  in  NUM_REQ*OP_W  packed ALU operation per requester (slice i = requester i)
req_src  in  NUM_REQ  per-requester operand-2 select (1 = immediate)
req_a  in  NUM_REQ*DATA_W  packed operand 1
req_b  in  NUM_REQ*DATA_W  packed operand 2 (register)
req_imm  in  NUM_REQ*DATA_W  packed immediate
alu_a  out  DATA_W  to ALU readdata1
alu_b  out  DATA_W  to ALU readdata2
alu_imm  out  DATA_W  to ALU immgen
alu_op  out  OP_W  to ALU aluoperation
alu_src  out  1  to ALU alusrc
alu_result  in  DATA_W  from ALU alu_output
alu_zero  in  1  from ALU zero_flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester index of the response
rsp_data  out  DATA_W  captured ALU result
rsp_zero  out  1  captured zero flag

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; alu_* registers 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, grant g = first valid index searching upward from ptr+1, wrapping at NUM_REQ.
  - req_ready[g] = 1 combinationally this cycle only.
  - On that edge, latch req_op/src/a/b/imm slice g into the alu_* registers and g into rsp_id; go to EXEC.
  - No valid: stay in IDLE, req_ready = 0.
- EXEC (1 cycle): ALU settles on the registered inputs. Capture alu_result → rsp_data and alu_zero → rsp_zero. Go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_data/rsp_zero/rsp_id remain stable until rsp_valid && rsp_ready.
  - On that handshake: ptr ← rsp_id, rsp_valid ← 0, go to IDLE.
  - req_ready = 0 throughout RESP.
- Latency and throughput:
  - Request accept → rsp_valid asserted: 2 clocks.
  - Minimum 3 clocks per operation with rsp_ready held high.
  - No new acceptance while a transaction is outstanding.
- alu_* outputs hold their last latched value while in IDLE and RESP; they change only on acceptance.
- Opcodes pass through unchecked. Unsupported codes yield rsp_data = 0 and rsp_zero = 0, per ALU.
- Requester dropping req_valid before grant: no effect, no penalty. A requester must hold its request stable until req_ready.
- Simultaneous requests: exactly one grant; the others wait. Round-robin guarantees each waiting requester is granted within NUM_REQ transactions.
- Reset asserted mid-transaction: the transaction is dropped with no response; all state returns to reset values immediately.
- rsp_ready asserted while rsp_valid = 0: ignored.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed.
- Undefined (default): round-robin as above. All else identical.

Decomposition:
- Package alu_arb_pkg contains:
  - state enum (IDLE, EXEC, RESP);
  - opcode constants ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;
  - default widths.
- One sub-module: rr_picker (inputs req vector and ptr; outputs one-hot grant and index). Contains the fixed-priority variant under the macro.

Test Plan:
- Req0 only, ADD, a = 5, b = 7, src = 0, rsp_ready = 1 → req_ready[0] pulses 1 cycle; rsp_valid 2 clocks later; rsp_data = 12, rsp_zero = 0, rsp_id = 0.
- Req1 SUB, a = 9, src = 1, imm = 9 → rsp_data = 0, rsp_zero = 1, rsp_id = 1.
- Both valid continuously, opcodes ADD/OR → grants alternate 0,1,0,1 (round-robin). With ALU_ARB_FIXED_PRIO_EN, grants are 0,0,0,0.
- rsp_ready held 0 for 5 clocks in RESP → rsp_valid/data/id stable; req_ready stays 0 despite req_valid; transaction completes when rsp_ready rises.
- Opcode 4'b1010, a = 0xFFFF_FFFF → rsp_data = 0, rsp_zero = 0.
- rst_n asserted during EXEC → rsp_valid = 0 immediately; after release, req1 and req0 both valid → requester 0 granted first.
